// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM state
// encoding, unit-select codes and the unit-enable decode.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // Enable vector bit order: {SHIFT, CMP, LOGIC, ARITH}.
    function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
        unit_onehot = 4'b0001 << unit;
    endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// WAIT-phase cycle counter for the sequencer timeout (built only when
// ALU_SEQ_TIMEOUT_EN is defined).
module alu_seq_timeout
    import alu_seq_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal on the flagless WAIT cycle whose increment brings the count to LIMIT.
    assign tc_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU sub-unit interface: accepts one command, pulses
// one unit enable, waits for that unit's flag and returns the result.
// Optional WAIT timeout is compiled in with ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [3:0]            CMD_OPCODE,
    input  logic [DATA_WIDTH-1:0] CMD_A,
    input  logic [DATA_WIDTH-1:0] CMD_B,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [1:0]            ALU_FUN,
    output logic                  ARITH_Enable,
    output logic                  LOGIC_Enable,
    output logic                  CMP_Enable,
    output logic                  SHIFT_Enable,
    input  logic [DATA_WIDTH-1:0] ARITH_OUT,
    input  logic [DATA_WIDTH-1:0] LOGIC_OUT,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                  ARITH_Flag,
    input  logic                  LOGIC_Flag,
    input  logic                  CMP_Flag,
    input  logic                  SHIFT_Flag,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_ERR,
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid, once raised, holds with its payload stable until transfer,
    // and ready never depends combinationally on valid.

    seq_state_e            state_q, state_d;
    logic [1:0]            unit_q, unit_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            fun_q, fun_d;
    logic [3:0]            en_q, en_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  accept;
    logic                  sel_flag;
    logic [DATA_WIDTH-1:0] sel_out;
    logic                  timeout_tc;

    assign accept = (state_q == IDLE) && CMD_VALID && cmd_ready_q;

    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (unit_q)
            UNIT_ARITH: begin sel_flag = ARITH_Flag; sel_out = ARITH_OUT; end
            UNIT_LOGIC: begin sel_flag = LOGIC_Flag; sel_out = LOGIC_OUT; end
            UNIT_CMP:   begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            UNIT_SHIFT: begin sel_flag = SHIFT_Flag; sel_out = SHIFT_OUT; end
            default:    begin sel_flag = 1'b0;       sel_out = '0;        end
        endcase
    end

    // State and registered-output register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            unit_q      <= UNIT_ARITH;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            en_q        <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            en_q        <= en_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sel_flag || timeout_tc) state_d = RESP;
            RESP:    if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: every output is the register of a value decided from state_d.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        unit_d     = unit_q;
        rsp_data_d = rsp_data_q;
        if (accept) begin
            a_d    = CMD_A;
            b_d    = CMD_B;
            fun_d  = CMD_OPCODE[1:0];
            unit_d = CMD_OPCODE[3:2];
        end
        if (state_q == WAIT) begin
            if (sel_flag) begin
                rsp_data_d = sel_out;
            end else if (timeout_tc) begin
                rsp_data_d = '0;
            end
        end
        en_d        = (state_d == ISSUE) ? unit_onehot(unit_d) : 4'b0000;
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    // WAIT is only ever entered from ISSUE, so ISSUE is the clear point.
    alu_seq_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK   (CLK),
        .RST   (RST),
        .clr_i (state_q == ISSUE),
        .en_i  ((state_q == WAIT) && !sel_flag),
        .tc_o  (timeout_tc)
    );

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (state_q == WAIT) begin
            if (sel_flag) begin
                rsp_err_d = 1'b0;
            end else if (timeout_tc) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign RSP_ERR = rsp_err_q;
`else
    logic unused_cfg;

    assign timeout_tc = 1'b0;
    assign RSP_ERR    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign CMD_READY    = cmd_ready_q;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign ARITH_Enable = en_q[0];
    assign LOGIC_Enable = en_q[1];
    assign CMP_Enable   = en_q[2];
    assign SHIFT_Enable = en_q[3];
    assign RSP_VALID    = rsp_valid_q;
    assign RSP_DATA     = rsp_data_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer; the bench also plays the four
// registered ALU sub-units with a programmable flag delay.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic          CMD_VALID, CMD_READY, RSP_VALID, RSP_READY, RSP_ERR;
    logic [3:0]    CMD_OPCODE;
    logic [DW-1:0] CMD_A, CMD_B, A, B, RSP_DATA;
    logic [1:0]    ALU_FUN, dbg_state;
    logic          ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable;
    logic [DW-1:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
    logic          ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag;

    alu_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OPCODE(CMD_OPCODE),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .ARITH_Enable(ARITH_Enable), .LOGIC_Enable(LOGIC_Enable),
        .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
        .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .ARITH_Flag(ARITH_Flag), .LOGIC_Flag(LOGIC_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .dbg_state_o(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW:0]   exp_q[$];
    int            en_cnt[4] = '{default: 0};
    int            cyc = 0;
    logic [3:0]    en_vec;

    assign en_vec = {SHIFT_Enable, CMP_Enable, LOGIC_Enable, ARITH_Enable};

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        for (int u = 0; u < 4; u++) begin
            if (en_vec[u]) en_cnt[u] = en_cnt[u] + 1;
        end
    end

    // ---------------- sub-unit models ----------------
    function automatic logic [DW-1:0] unit_model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        case (op[3:2])
            UNIT_ARITH: case (op[1:0])
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a * b;
                default: r = (b == 0) ? '0 : a / b;
            endcase
            UNIT_LOGIC: case (op[1:0])
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = ~(a & b);
                default: r = ~(a | b);
            endcase
            UNIT_CMP: case (op[1:0])
                2'd0: r = '0;
                2'd1: r = (a == b) ? 16'd1 : 16'd0;
                2'd2: r = (a > b) ? 16'd2 : 16'd0;
                default: r = (a < b) ? 16'd3 : 16'd0;
            endcase
            default: case (op[1:0])
                2'd0: r = a >> 1;
                2'd1: r = a << 1;
                2'd2: r = b >> 1;
                default: r = b << 1;
            endcase
        endcase
        return r;
    endfunction

    int            unit_delay = 0;
    logic          noise = 1'b0;
    logic          busy;
    int            cnt;
    logic [1:0]    bu;
    logic [DW-1:0] res;
    logic [1:0]    en_unit;
    logic          hit;

    assign en_unit = CMP_Enable ? UNIT_CMP : LOGIC_Enable ? UNIT_LOGIC : SHIFT_Enable ? UNIT_SHIFT : UNIT_ARITH;
    assign hit     = busy && (cnt == 0);

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy <= 1'b0;
            cnt  <= 0;
            bu   <= UNIT_ARITH;
            res  <= '0;
        end else if (|en_vec) begin
            busy <= 1'b1;
            cnt  <= unit_delay;
            bu   <= en_unit;
            res  <= unit_model({en_unit, ALU_FUN}, A, B);
        end else if (busy) begin
            if (cnt == 0) busy <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    // Unselected units show garbage data and, with noise set, a stuck-high flag.
    assign ARITH_OUT  = (bu == UNIT_ARITH) ? res : 16'hBEEF;
    assign LOGIC_OUT  = (bu == UNIT_LOGIC) ? res : 16'hBEEF;
    assign CMP_OUT    = (bu == UNIT_CMP)   ? res : 16'hBEEF;
    assign SHIFT_OUT  = (bu == UNIT_SHIFT) ? res : 16'hBEEF;
    assign ARITH_Flag = (hit && bu == UNIT_ARITH) || (noise && bu != UNIT_ARITH);
    assign LOGIC_Flag = (hit && bu == UNIT_LOGIC) || (noise && bu != UNIT_LOGIC);
    assign CMP_Flag   = (hit && bu == UNIT_CMP)   || (noise && bu != UNIT_CMP);
    assign SHIFT_Flag = (hit && bu == UNIT_SHIFT) || (noise && bu != UNIT_SHIFT);

    // ---------------- checking / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge with the DUT in IDLE.
    task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int delay, input int bp, input bit tmo, input int lat_exp);
        logic [DW:0] exp_v, got;
        int          lat, pre;
        bit          held_ok, quiet_ok;
        exp_v = tmo ? {1'b1, {DW{1'b0}}} : {1'b0, unit_model(op, a, b)};
        unit_delay = delay;
        chk("idle_ready", 32'(CMD_READY), 32'd1);
        CMD_VALID  = 1'b1;
        CMD_OPCODE = op;
        CMD_A      = a;
        CMD_B      = b;
        RSP_READY  = (bp == 0);
        exp_q.push_back(exp_v);
        pre = en_cnt[op[3:2]];
        @(negedge CLK);
        CMD_VALID  = 1'b0;
        CMD_A      = DW'($urandom_range(0, 65535));
        CMD_B      = DW'($urandom_range(0, 65535));
        CMD_OPCODE = 4'($urandom_range(0, 15));
        chk("issue_en", 32'(en_vec), 32'(unit_onehot(op[3:2])));
        chk("issue_fun", 32'(ALU_FUN), 32'(op[1:0]));
        chk("issue_a", 32'(A), 32'(a));
        chk("issue_b", 32'(B), 32'(b));
        chk("issue_ready", 32'(CMD_READY), 32'd0);
        lat = 0;
        held_ok = 1'b1;
        quiet_ok = 1'b1;
        do begin
            @(negedge CLK);
            lat++;
            if (A !== a || B !== b || ALU_FUN !== op[1:0]) held_ok = 1'b0;
            if (en_vec !== 4'b0000 || CMD_READY !== 1'b0) quiet_ok = 1'b0;
        end while (RSP_VALID !== 1'b1 && lat < 64);
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("operands_held", 32'(held_ok), 32'd1);
        chk("quiet_in_wait", 32'(quiet_ok), 32'd1);
        got = exp_q.pop_front();
        for (int i = 0; i < bp; i++) begin
            @(negedge CLK);
            chk("bp_valid", 32'(RSP_VALID), 32'd1);
            chk("bp_data", 32'(RSP_DATA), 32'(got[DW-1:0]));
            chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
        end
        chk("rsp_data", 32'(RSP_DATA), 32'(got[DW-1:0]));
        chk("rsp_err", 32'(RSP_ERR), 32'(got[DW]));
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        chk("post_valid", 32'(RSP_VALID), 32'd0);
        chk("post_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("post_a_held", 32'(A), 32'(a));
        chk("enable_once", 32'(en_cnt[op[3:2]] - pre), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [3:0]    b2b_op[4] = '{4'b0010, 4'b0111, 4'b1000, 4'b1111};
    logic [DW-1:0] b2b_a[4]  = '{16'd300, 16'h5A5A, 16'd77, 16'h0123};
    logic [DW-1:0] b2b_b[4]  = '{16'd7, 16'h0F0F, 16'd77, 16'h8001};

    initial begin
        int          d, lat, acc, prev_acc;
        int          pre_cnt[4];
        logic [3:0]  rop;
        logic [DW:0] got;

        CMD_VALID  = 1'b0;
        CMD_OPCODE = '0;
        CMD_A      = '0;
        CMD_B      = '0;
        RSP_READY  = 1'b0;
        acc        = 0;
        prev_acc   = 0;

        #12;
        chk("reset_ctl", 32'({CMD_READY, ALU_FUN, en_vec, RSP_VALID, RSP_ERR, dbg_state}), 32'd0);
        chk("reset_ab", 32'({A, B}), 32'd0);
        chk("reset_data", 32'(RSP_DATA), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("release_ready", 32'(CMD_READY), 32'd1);

        run_op(4'b1001, 16'd5, 16'd5, 0, 0, 1'b0, 2);
        run_op(4'b1010, 16'd9, 16'd3, 0, 0, 1'b0, 2);
        run_op(4'b1011, 16'd2, 16'd7, 0, 0, 1'b0, 2);
        run_op(4'b0000, 16'd1234, 16'd4321, 0, 0, 1'b0, 2);
        run_op(4'b0101, 16'hF000, 16'h000F, 0, 0, 1'b0, 2);
        run_op(4'b1101, 16'h4001, 16'h0000, 0, 0, 1'b0, 2);
        run_op(4'b0001, 16'd100, 16'd30, 0, 5, 1'b0, 2);

        noise = 1'b1;
        run_op(4'b0110, 16'h00F0, 16'h0FF0, 3, 0, 1'b0, 5);
        noise = 1'b0;

        for (int i = 0; i < 6; i++) begin
            d   = $urandom_range(0, 3);
            rop = 4'($urandom_range(0, 15));
            run_op(rop, DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)), d, $urandom_range(0, 2), 1'b0, 2 + d);
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        noise = 1'b1;
        run_op(4'b1101, 16'd11, 16'd22, 1000, 0, 1'b1, 9);
        noise = 1'b0;
        run_op(4'b0011, 16'd40, 16'd5, 7, 0, 1'b0, 9);
        run_op(4'b0100, 16'h1234, 16'h00FF, 6, 0, 1'b0, 8);
`endif

        // Reset while the selected unit never answers.
        unit_delay = 1000;
        CMD_VALID  = 1'b1;
        CMD_OPCODE = 4'b0100;
        CMD_A      = 16'hA5A5;
        CMD_B      = 16'h5A5A;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_reset_wait", 32'(dbg_state), 32'(WAIT));
        #2 RST = 1'b0;
        #1;
        chk("async_rst_ctl", 32'({CMD_READY, ALU_FUN, en_vec, RSP_VALID, RSP_ERR, dbg_state}), 32'd0);
        chk("async_rst_ab", 32'({A, B}), 32'd0);
        chk("async_rst_data", 32'(RSP_DATA), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        unit_delay = 0;
        @(negedge CLK);
        chk("rerelease_ready", 32'(CMD_READY), 32'd1);
        run_op(4'b1001, 16'd8, 16'd8, 0, 0, 1'b0, 2);

        // Back-to-back with CMD_VALID held high and RSP_READY always 1.
        for (int u = 0; u < 4; u++) pre_cnt[u] = en_cnt[u];
        RSP_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_ready", 32'(CMD_READY), 32'd1);
            CMD_VALID  = 1'b1;
            CMD_OPCODE = b2b_op[k];
            CMD_A      = b2b_a[k];
            CMD_B      = b2b_b[k];
            exp_q.push_back({1'b0, unit_model(b2b_op[k], b2b_a[k], b2b_b[k])});
            acc = cyc + 1;
            if (k > 0) chk("b2b_gap", 32'(acc - prev_acc), 32'd4);
            prev_acc = acc;
            @(negedge CLK);
            chk("b2b_en", 32'(en_vec), 32'(unit_onehot(b2b_op[k][3:2])));
            lat = 0;
            do begin
                @(negedge CLK);
                lat++;
            end while (RSP_VALID !== 1'b1 && lat < 64);
            chk("b2b_latency", 32'(lat), 32'd2);
            got = exp_q.pop_front();
            chk("b2b_data", 32'(RSP_DATA), 32'(got[DW-1:0]));
            chk("b2b_err", 32'(RSP_ERR), 32'(got[DW]));
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        RSP_READY = 1'b0;
        for (int u = 0; u < 4; u++) chk("b2b_en_once", 32'(en_cnt[u] - pre_cnt[u]), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
